// File: rtl/instr_encode_loader_pkg.sv
// Shared definitions for the instruction loader: opcode map, op indices,
// instruction field positions and loader FSM states.
package instr_encode_loader_pkg;

  // Opcodes, identical to the decoder's map.
  localparam logic [5:0] OPC_ADD  = 6'b000001;
  localparam logic [5:0] OPC_SUB  = 6'b000010;
  localparam logic [5:0] OPC_INC  = 6'b000011;
  localparam logic [5:0] OPC_DEC  = 6'b000100;
  localparam logic [5:0] OPC_AND  = 6'b000101;
  localparam logic [5:0] OPC_OR   = 6'b000110;
  localparam logic [5:0] OPC_XOR  = 6'b000111;
  localparam logic [5:0] OPC_NOT  = 6'b001000;
  localparam logic [5:0] OPC_SLL  = 6'b001001;
  localparam logic [5:0] OPC_SRL  = 6'b001010;
  localparam logic [5:0] OPC_ADDI = 6'b001011;
  localparam logic [5:0] OPC_SUBI = 6'b001100;
  localparam logic [5:0] OPC_LW   = 6'b100010;
  localparam logic [5:0] OPC_SW   = 6'b100100;

  // Command op indices.
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_INC  = 4'd2;
  localparam logic [3:0] OP_DEC  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_ADDI = 4'd10;
  localparam logic [3:0] OP_SUBI = 4'd11;
  localparam logic [3:0] OP_LW   = 4'd12;
  localparam logic [3:0] OP_SW   = 4'd13;

  // Field LSB positions within the 32-bit word.
  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int IMM_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FULL  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Returns {legal, opcode}; indices 14 and 15 are illegal.
  function automatic logic [6:0] op_lookup(input logic [3:0] op);
    logic [6:0] r;
    r = 7'd0;
    case (op)
      OP_ADD:  r = {1'b1, OPC_ADD};
      OP_SUB:  r = {1'b1, OPC_SUB};
      OP_INC:  r = {1'b1, OPC_INC};
      OP_DEC:  r = {1'b1, OPC_DEC};
      OP_AND:  r = {1'b1, OPC_AND};
      OP_OR:   r = {1'b1, OPC_OR};
      OP_XOR:  r = {1'b1, OPC_XOR};
      OP_NOT:  r = {1'b1, OPC_NOT};
      OP_SLL:  r = {1'b1, OPC_SLL};
      OP_SRL:  r = {1'b1, OPC_SRL};
      OP_ADDI: r = {1'b1, OPC_ADDI};
      OP_SUBI: r = {1'b1, OPC_SUBI};
      OP_LW:   r = {1'b1, OPC_LW};
      OP_SW:   r = {1'b1, OPC_SW};
      default: r = 7'd0;
    endcase
    return r;
  endfunction

  function automatic logic is_itype(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/instr_encode_loader_encoder.sv
// Combinational op index + fields -> {word, legal} encoder.
module instr_encoder
  import instr_encode_loader_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  logic [6:0] lookup;
  logic [5:0] opcode;
  logic [4:0] shamt_eff;

  always_comb begin
    lookup    = op_lookup(op);
    legal     = lookup[6];
    opcode    = lookup[5:0];
    // Only shifts carry a shift amount; everything else encodes zero there.
    shamt_eff = ((op == OP_SLL) || (op == OP_SRL)) ? shamt : 5'd0;
    word      = 32'd0;
    if (legal) begin
      if (is_itype(op)) begin
        word = (32'(opcode) << OPC_LSB) | (32'(rs) << RS_LSB) |
               (32'(rt) << RT_LSB) | (32'(imm) << IMM_LSB);
      end else begin
        word = (32'(opcode) << OPC_LSB) | (32'(rs) << RS_LSB) |
               (32'(rt) << RT_LSB) | (32'(rd) << RD_LSB) |
               (32'(shamt_eff) << SHAMT_LSB);
      end
    end
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Instruction-memory loader: accepts commands, encodes them and writes one
// word per two cycles sequentially from a programmable base address.
module instr_encode_loader
  import instr_encode_loader_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          finish,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [4:0]    cmd_rs,
  input  logic [4:0]    cmd_rt,
  input  logic [4:0]    cmd_rd,
  input  logic [4:0]    cmd_shamt,
  input  logic [15:0]   cmd_imm,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [AW:0]   word_count,
  output logic          busy,
  output logic          full,
  output logic          done,
  output logic          err_illegal,
  output state_t        dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
  // cmd_ready never depends on cmd_valid; the command must stay stable until then.

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q;
  logic [31:0]   wdata_q;
  logic [AW:0]   count_q;
  logic          err_q;

  logic [31:0]   enc_word;
  logic          enc_legal;
  logic          at_last;
  logic          session_start;
  logic          accept_word;
  logic          accept_illegal;
  logic          write_commit;

  instr_encoder u_encoder (
    .op    (cmd_op),
    .rs    (cmd_rs),
    .rt    (cmd_rt),
    .rd    (cmd_rd),
    .shamt (cmd_shamt),
    .imm   (cmd_imm),
    .word  (enc_word),
    .legal (enc_legal)
  );

  assign at_last = (ptr_q == AW'(DEPTH - 1));

  always_comb begin
    state_d        = state_q;
    session_start  = 1'b0;
    accept_word    = 1'b0;
    accept_illegal = 1'b0;
    write_commit   = 1'b0;
    cmd_ready      = 1'b0;
    imem_we        = 1'b0;
    busy           = 1'b0;
    full           = 1'b0;
    done           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          session_start = 1'b1;
          state_d       = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy      = 1'b1;
        cmd_ready = !finish;
        if (finish) begin
          state_d = ST_DONE;
        end else if (cmd_valid) begin
          // Illegal ops are consumed without a write so the address stream has no gap.
          if (enc_legal) begin
            accept_word = 1'b1;
            state_d     = ST_WRITE;
          end else begin
            accept_illegal = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        busy         = 1'b1;
        imem_we      = 1'b1;
        write_commit = 1'b1;
        state_d      = at_last ? ST_FULL : ST_LOAD;
      end
      ST_FULL: begin
        full = 1'b1;
        if (finish) begin
          state_d = ST_DONE;
        end else if (start) begin
          session_start = 1'b1;
          state_d       = ST_LOAD;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (session_start) begin
        ptr_q   <= base_addr;
        count_q <= '0;
        err_q   <= 1'b0;
      end
      if (accept_word) wdata_q <= enc_word;
      if (accept_illegal) err_q <= 1'b1;
      if (write_commit) begin
        count_q <= count_q + (AW + 1)'(1);
        // Pointer stays on the last address once memory is full; it never wraps.
        if (!at_last) ptr_q <= ptr_q + AW'(1);
      end
    end
  end

  assign imem_addr   = ptr_q;
  assign imem_wdata  = wdata_q;
  assign word_count  = count_q;
  assign err_illegal = err_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Instruction-memory writer that sits at the opposite end of the opcode decoder.
- Accepts operation commands over a valid/ready handshake and encodes each one into a 32-bit instruction word using the core's opcode map.
- Writes each word sequentially into instruction memory from a programmable base address.
- Used by the testbench/boot path to load programs that the decoder later consumes.

Parameters:
- AW, 5, instruction-memory address width.
- DEPTH, 32, number of instruction words; last writable address is DEPTH-1 (DEPTH <= 2**AW).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  pulse: begin a load session at base_addr.
- base_addr  input  AW  first write address.
- finish  input  1  pulse: end the load session.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when valid&&ready.
- cmd_op  input  4  op index: 0 ADD, 1 SUB, 2 INC, 3 DEC, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 SLL, 9 SRL, 10 ADDI, 11 SUBI, 12 LW, 13 SW; 14-15 illegal.
- cmd_rs, cmd_rt, cmd_rd  input  5 each  register fields.
- cmd_shamt  input  5  shift amount.
- cmd_imm  input  16  immediate/offset.
- imem_we  output  1  write strobe.
- imem_addr  output  AW  write address.
- imem_wdata  output  32  encoded word.
- word_count  output  AW+1  words written this session.
- busy  output  1  session active (LOAD or WRITE).
- full  output  1  last address written.
- done  output  1  one-cycle pulse on session end.
- err_illegal  output  1  sticky; illegal op seen this session.

Behaviour:
- Reset: state IDLE; cmd_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, word_count=0, busy=0, full=0, done=0, err_illegal=0. Reset mid-write aborts with no further strobe.
- Opcodes: ADD 000001, SUB 000010, INC 000011, DEC 000100, AND 000101, OR 000110, XOR 000111, NOT 001000, SLL 001001, SRL 001010, ADDI 001011, SUBI 001100, LW 100010, SW 100100.
- R-type (ops 0-9): {opcode, rs, rt, rd, shamt, 6'b0}. shamt is forced to 0 except for SLL/SRL.
- I-type (ops 10-13): {opcode, rs, rt, imm}. rd and shamt are ignored.
- IDLE:
  - cmd_ready=0.
  - start latches base_addr into the write pointer, clears word_count, full and err_illegal, then goes to LOAD.
  - finish is ignored.
- LOAD:
  - cmd_ready = !finish.
  - finish high: go to DONE.
  - Handshake with legal op: register the encoded word, go to WRITE.
  - Handshake with illegal op: consume the command, set err_illegal, write nothing, stay in LOAD.
  - start is ignored.
- WRITE (one cycle):
  - imem_we=1, with imem_addr/imem_wdata from the registers; cmd_ready=0.
  - Next cycle: pointer+1, word_count+1.
  - If the written address is DEPTH-1: go to FULL, else LOAD.
  - Throughput is 1 word per 2 cycles. Latency from handshake to imem_we is 1 cycle.
- FULL:
  - full=1, cmd_ready=0, busy=0.
  - finish goes to DONE.
  - start restarts the session (as from IDLE).
  - The pointer never wraps.
- DONE: done=1 for one cycle, then IDLE. word_count and err_illegal are held until the next start.
- busy=1 only in LOAD and WRITE.
- imem_we is never asserted outside WRITE.

Decomposition:
- Shared package holds:
  - opcode constants (same values as the decoder);
  - op-index constants;
  - R/I field position constants;
  - FSM state encodings.
- Sub-module instr_encoder: a purely combinational op index + fields -> {word, legal} mapping, reusable by the verification model.
- The top holds the FSM, pointer and counters.

Test Plan:
- Encode check: start with base 0; ADD rs=1 rt=2 rd=3 -> imem_we one cycle after handshake, addr 0, wdata 0x04221800; word_count=1.
- Encode check: ADDI rs=4 rt=5 imm=0x0010 -> 0x2C850010; LW rs=0 rt=8 imm=0x0004 -> 0x88080004; SLL rt=2 rd=3 shamt=4 -> 0x24021900; ADD with shamt=7 -> shamt field 0.
- Full condition: DEPTH=4, start base=2, two commands -> writes at 2 and 3, then full=1 and cmd_ready=0; a third cmd_valid is held unaccepted and produces no imem_we.
- Illegal op 14 between two ADDs -> err_illegal=1, addresses 0 then 1 (no gap), word_count=2.
- Simultaneous finish with cmd_valid in LOAD -> cmd_ready=0, no write, done pulse, then IDLE.
- rst asserted in the WRITE cycle -> next cycle all outputs at reset values; a fresh start works normally.
